// File: rtl/spi_reg_ctrl_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register controller.
// Used by spi_reg_ctrl and its testbench.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_CAP,
    RD
  } state_t;

  localparam int         CMD_READ_BIT  = 7;
  localparam logic [3:0] STATUS_MAGIC  = 4'hA;
  localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: byte-engine strobes, SS pin and register-file bus.
// slave = controller view, master = environment view.
interface spi_reg_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = WIDTH - 1
);
  logic             ss_n;
  logic [WIDTH-1:0] spi_rxdata;
  logic             spi_rxready;
  logic             spi_txready;
  logic [WIDTH-1:0] spi_txdata;
  logic [AW-1:0]    reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic             reg_we;
  logic             reg_re;
  logic [WIDTH-1:0] reg_rdata;
  logic             busy;
  logic             err;

  modport slave (
    input  ss_n, spi_rxdata, spi_rxready,
    input  spi_txready, reg_rdata,
    output spi_txdata, reg_addr, reg_wdata,
    output reg_we, reg_re, busy, err
  );

  modport master (
    output ss_n, spi_rxdata, spi_rxready,
    output spi_txready, reg_rdata,
    input  spi_txdata, reg_addr, reg_wdata,
    input  reg_we, reg_re, busy, err
  );
endinterface

// File: rtl/spi_reg_ctrl_ss_sync.sv
// spi_ss_sync: 2-flop synchroniser for an active-low SS pin.
// Gives the select level plus one-cycle rise/fall pulses.
module spi_ss_sync (
  input  logic clk,
  input  logic resetn,
  input  logic ss_n,
  output logic sel,
  output logic sel_rise,
  output logic sel_fall
);
  logic [1:0] sync_q;
  logic       prev_q;

  // Presets to deselected so reset never looks like a frame edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], ss_n};
      prev_q <= sync_q[1];
    end
  end

  assign sel      = ~sync_q[1];
  assign sel_rise = ~sync_q[1] & prev_q;
  assign sel_fall = sync_q[1] & ~prev_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI command decoder with auto-increment register access.
// Define SPI_REG_CTRL_STATUS_EN for the {A, frame count} status byte.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = WIDTH - 1
) (
  input logic           clk,
  input logic           resetn,
  spi_reg_ctrl_if.slave bus
);
  state_t           state;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addr_nx;
  logic [WIDTH-1:0] txbuf;
  logic             txvalid;
  logic             sel;
  logic             sel_rise;
  logic             sel_fall;
  logic             err_q;
  logic             we_q;
  logic             re_q;
  logic [AW-1:0]    raddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] txdata;

  spi_ss_sync u_ss_sync (
    .clk      (clk),
    .resetn   (resetn),
    .ss_n     (bus.ss_n),
    .sel      (sel),
    .sel_rise (sel_rise),
    .sel_fall (sel_fall)
  );

  assign addr_nx = addr + AW'(1);

`ifdef SPI_REG_CTRL_STATUS_EN
  logic [3:0] xact_cnt;

  // Count completed frames, wrapping at 16
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xact_cnt <= '0;
    end else if (sel_fall) begin
      xact_cnt <= xact_cnt + 4'd1;
    end
  end

  assign status = WIDTH'({STATUS_MAGIC, xact_cnt});
`else
  logic unused_fall;
  assign unused_fall = sel_fall;
  assign status      = '0;
`endif

  // Transaction FSM; strobes default low and last one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      addr    <= '0;
      txbuf   <= '0;
      txvalid <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (!sel) begin
        state   <= IDLE;
        txvalid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (sel_rise) begin
              err_q <= 1'b0;
              state <= CMD;
            end
          end
          CMD: begin
            if (bus.spi_rxready) begin
              addr <= bus.spi_rxdata[AW-1:0];
              if (bus.spi_rxdata[CMD_READ_BIT]) begin
                re_q    <= 1'b1;
                raddr_q <= bus.spi_rxdata[AW-1:0];
                state   <= RD_REQ;
              end else begin
                state <= WR;
              end
            end
          end
          WR: begin
            if (we_q) begin
              addr <= addr_nx;
            end
            if (bus.spi_rxready) begin
              we_q    <= 1'b1;
              raddr_q <= addr;
              wdata_q <= bus.spi_rxdata;
            end
          end
          RD_REQ: begin
            if (bus.spi_txready) begin
              err_q   <= 1'b1;
              addr    <= addr_nx;
              re_q    <= 1'b1;
              raddr_q <= addr_nx;
              state   <= RD_REQ;
            end else begin
              state <= RD_CAP;
            end
          end
          RD_CAP: begin
            if (bus.spi_txready) begin
              err_q   <= 1'b1;
              addr    <= addr_nx;
              re_q    <= 1'b1;
              raddr_q <= addr_nx;
              state   <= RD_REQ;
            end else begin
              txbuf   <= bus.reg_rdata;
              txvalid <= 1'b1;
              state   <= RD;
            end
          end
          RD: begin
            if (bus.spi_txready) begin
              if (!txvalid) begin
                err_q <= 1'b1;
              end
              txvalid <= 1'b0;
              addr    <= addr_nx;
              re_q    <= 1'b1;
              raddr_q <= addr_nx;
              state   <= RD_REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // MISO byte; all-ones whenever the byte engine outruns the prefetch
  always_comb begin
    txdata = '0;
    unique case (state)
      IDLE, CMD: txdata = status;
      RD: begin
        txdata = txvalid ? txbuf : WIDTH'(UNDERRUN_BYTE);
      end
      RD_REQ, RD_CAP: begin
        txdata = bus.spi_txready ? WIDTH'(UNDERRUN_BYTE) : '0;
      end
      default: txdata = '0;
    endcase
  end

  assign bus.spi_txdata = txdata;
  assign bus.reg_addr   = raddr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.reg_we     = we_q;
  assign bus.reg_re     = re_q;
  assign bus.busy       = sel;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: scoreboard bench for spi_reg_ctrl.
// Status expectations follow SPI_REG_CTRL_STATUS_EN when defined.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tb_xact = 0;

  logic [7:0]  mem [128];
  logic [7:0]  miso_q [$];
  logic [14:0] wr_q [$];
  logic [6:0]  re_q [$];

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
`ifdef SPI_REG_CTRL_STATUS_EN
    logic [31:0] c;
    c = tb_xact;
    return {4'hA, c[3:0]};
`else
    return 8'h00;
`endif
  endfunction

  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  always @(negedge clk) begin
    if (resetn && bus.reg_we) begin
      if (wr_q.size() == 0) chk("we_unexpected", 1, 0);
      else chk("we", {bus.reg_addr, bus.reg_wdata},
               wr_q.pop_front());
    end
    if (resetn && bus.reg_re) begin
      if (re_q.size() == 0) chk("re_unexpected", 1, 0);
      else chk("re_addr", bus.reg_addr, re_q.pop_front());
    end
    if (resetn && bus.spi_txready) begin
      if (miso_q.size() == 0) chk("miso_unexpected", 1, 0);
      else chk("miso", bus.spi_txdata, miso_q.pop_front());
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx();
    bus.spi_txready = 1'b1;
    tick(1);
    bus.spi_txready = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    bus.spi_rxdata  = d;
    bus.spi_rxready = 1'b1;
    tick(1);
    bus.spi_rxready = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mosi,
                          input logic [7:0] miso);
    miso_q.push_back(miso);
    pulse_tx();
    tick(6);
    pulse_rx(mosi);
    tick(6);
  endtask

  task automatic frame_start();
    bus.ss_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    bus.ss_n = 1'b1;
    tick(4);
    tb_xact++;
  endtask

  initial begin
    resetn          = 1'b0;
    bus.ss_n        = 1'b1;
    bus.spi_rxdata  = '0;
    bus.spi_rxready = 1'b0;
    bus.spi_txready = 1'b0;
    bus.reg_rdata   = '0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 1);
    mem[7'h10] = 8'hA0;
    mem[7'h11] = 8'hB1;
    mem[7'h12] = 8'hC2;
    tick(3);
    @(negedge clk);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_re", bus.reg_re, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_txdata", bus.spi_txdata, exp_status());
    tick(1);
    resetn = 1'b1;
    tick(2);

    // write burst
    frame_start();
    chk("busy_in_frame", bus.busy, 1);
    wr_q.push_back({7'h05, 8'h11});
    wr_q.push_back({7'h06, 8'h22});
    wr_q.push_back({7'h07, 8'h33});
    spi_byte(8'h05, exp_status());
    spi_byte(8'h11, 8'h00);
    spi_byte(8'h22, 8'h00);
    spi_byte(8'h33, 8'h00);
    chk("wr_err", bus.err, 0);
    frame_end();

    // read burst with prefetch
    re_q.push_back(7'h10);
    re_q.push_back(7'h11);
    re_q.push_back(7'h12);
    re_q.push_back(7'h13);
    frame_start();
    spi_byte(8'h90, exp_status());
    spi_byte(8'h00, 8'hA0);
    spi_byte(8'h00, 8'hB1);
    spi_byte(8'h00, 8'hC2);
    chk("rd_err", bus.err, 0);
    frame_end();

    // address wrap
    wr_q.push_back({7'h7F, 8'h01});
    wr_q.push_back({7'h00, 8'h02});
    frame_start();
    spi_byte(8'h7F, exp_status());
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h02, 8'h00);
    frame_end();

    // underrun right after the read command
    frame_start();
    miso_q.push_back(exp_status());
    pulse_tx();
    tick(6);
    re_q.push_back(7'h11);
    re_q.push_back(7'h12);
    pulse_rx(8'h91);
    miso_q.push_back(8'hFF);
    pulse_tx();
    tick(2);
    chk("underrun_err", bus.err, 1);
    tick(6);
    frame_end();
    chk("err_sticky", bus.err, 1);
    frame_start();
    chk("err_cleared", bus.err, 0);
    spi_byte(8'h00, exp_status());
    frame_end();

    // abort after write command without data
    frame_start();
    spi_byte(8'h20, exp_status());
    bus.ss_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_1clk", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_2clk", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle", 32'(dut.state), 32'(IDLE));
    tick(2);
    tb_xact++;
    wr_q.push_back({7'h03, 8'h44});
    frame_start();
    spi_byte(8'h03, exp_status());
    spi_byte(8'h44, 8'h00);
    frame_end();

    // reset in the middle of a read
    re_q.push_back(7'h10);
    re_q.push_back(7'h11);
    frame_start();
    spi_byte(8'h90, exp_status());
    miso_q.push_back(8'hA0);
    pulse_tx();
    tick(4);
    chk("pre_rst_state", 32'(dut.state), 32'(RD));
    resetn  = 1'b0;
    tb_xact = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", bus.reg_we, 0);
    chk("mid_rst_re", bus.reg_re, 0);
    chk("mid_rst_addr", bus.reg_addr, 0);
    chk("mid_rst_wdata", bus.reg_wdata, 0);
    chk("mid_rst_txdata", bus.spi_txdata, exp_status());
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    bus.ss_n = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(2);

    // status after three completed frames
    for (int k = 0; k < 3; k++) begin
      frame_start();
      frame_end();
    end
    frame_start();
`ifdef SPI_REG_CTRL_STATUS_EN
    chk("status_a3", exp_status(), 8'hA3);
`endif
    spi_byte(8'h00, exp_status());
    frame_end();

    tick(4);
    chk("miso_q_empty", miso_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("re_q_empty", re_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
